dmem_wait_responder: RTL
========================

# dmem_wait_responder

Multi-cycle data-memory responder for the mips_16 pipeline: the memory-side end of the MEM-stage data access. It accepts one word read or write request through a valid/ready handshake and holds it for a programmable number of wait states. It then performs the access on an internal word array and returns a one-cycle response pulse with read data. `busy` feeds the hazard unit so the MEM stage can stall while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; the array holds 2^ADDR_W 16-bit words.
- `WAIT_CYCLES`, default 2: wait states inserted before the access, legal range 0..15.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  word address (ALU result).
- `req_wdata`  in  16  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  16  read data; for writes, echo of the written data.
- `rsp_err`  out  1  out-of-range access flag, qualified by `rsp_valid`.
- `busy`  out  1  access outstanding; stall request to the hazard unit.

## Operation
- States:
  - IDLE: no access outstanding.
  - WAIT: access outstanding, counting wait states.
  - RESP: response being presented.
- `req_ready` = 1 in IDLE and in RESP, 0 in WAIT.
- `busy` = (state == WAIT).
- Accept: `req_valid && req_ready` at an edge.
  - Latches `req_write`, `req_addr`, `req_wdata`.
  - Loads the counter with `WAIT_CYCLES`.
  - Next state is WAIT.
- WAIT, counter != 0: decrement, stay in WAIT.
- WAIT, counter == 0: perform the access at this edge, then go to RESP.
  - Write: array[addr] <= wdata; `rsp_rdata` <= wdata.
  - Read: `rsp_rdata` <= array[addr].
- RESP: `rsp_valid` = 1 for exactly this cycle.
  - Next state is WAIT if a new request is accepted in the same cycle, otherwise IDLE.
- Addressing: word-addressed using `req_addr[ADDR_W-1:0]`. Upper bits are ignored unless the range check is compiled in (see Configuration).
- The counter is 4 bits and does not wrap.
- The array is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready` 1, `busy` 0, `rsp_valid` 0, `rsp_rdata` 0x0000, `rsp_err` 0, counter 0.
- A request accepted at edge E produces `rsp_valid` high during the cycle after edge E+WAIT_CYCLES+1, i.e. latency WAIT_CYCLES+2 cycles.
- `busy` is high for WAIT_CYCLES+1 cycles per access.
- Maximum throughput: one access per WAIT_CYCLES+2 cycles, using back-to-back accept during RESP.
- `rsp_rdata` is registered and holds its value until the next response; `rsp_err` has the same hold behaviour.
- Read-after-write to the same address returns the new data, because accesses are strictly serialized.
- Requests while `req_ready` = 0 are ignored. The requester must hold `req_valid` and all request fields stable until accepted.
- Reset mid-access (in WAIT): the transaction is abandoned, no array write occurs, and no response is issued.
- Reset during RESP: `rsp_valid` drops at the reset edge, and any request presented that cycle is not accepted.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined:
  - An access with `req_addr[15:ADDR_W]` != 0 is out of range.
  - The write is suppressed, `rsp_rdata` = 0x0000, and `rsp_err` = 1 with the response.
  - Latency is unchanged.
- `DMEM_RANGE_CHECK_EN` undefined:
  - Upper address bits alias into the array.
  - `rsp_err` is tied to 0.

## Test plan
- Reset, then idle: `req_ready` = 1, `busy` = 0, `rsp_valid` = 0, `rsp_rdata` = 0x0000.
- WAIT_CYCLES = 2: write 0xBEEF to addr 0x0005, then read 0x0005.
  - Each `rsp_valid` arrives exactly 4 cycles after its accept.
  - Read returns 0xBEEF.
  - `busy` is high for 3 cycles per access.
- Back-to-back: second request held valid from accept of the first.
  - Second request is accepted in the RESP cycle.
  - Responses are spaced 4 cycles apart.
  - Writes 0x1111 and 0x2222 to addrs 1 and 2 read back correctly.
- WAIT_CYCLES = 0: read of a previously written addr 0x00 (0x00AA) returns `rsp_valid` 2 cycles after accept; `busy` high for 1 cycle.
- `rst` asserted in WAIT of a write of 0x5555 to addr 3, where addr 3 already holds 0x1234.
  - No `rsp_valid` is issued.
  - A later read of addr 3 returns 0x1234.
- With `DMEM_RANGE_CHECK_EN`, ADDR_W = 8: write 0x7777 to 0x0103.
  - `rsp_err` = 1 and `rsp_rdata` = 0x0000.
  - Addr 0x03 is unchanged.
  - Without the macro, the same write lands at 0x03 and `rsp_err` = 0.

Source files
------------

// File: rtl/dmem_wait_responder.sv
// Multi-cycle data-memory responder: one outstanding word access, WAIT_CYCLES wait states,
// one-cycle response pulse. Optional out-of-range checking via DMEM_RANGE_CHECK_EN.
module dmem_wait_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              oor_q, oor_in;
  logic              accept, access;
  logic [15:0]       mem [2**ADDR_W];

`ifdef DMEM_RANGE_CHECK_EN
  assign oor_in = (req_addr >> ADDR_W) != 16'd0;
`else
  // Upper address bits alias into the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(req_addr >> ADDR_W);
  assign oor_in = 1'b0;
`endif

  assign req_ready = (state != WAIT);
  assign busy      = (state == WAIT);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign access    = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = accept ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 16'h0000;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (access) begin
        rsp_err <= oor_q;
        if (oor_q)        rsp_rdata <= 16'h0000;
        else if (write_q) rsp_rdata <= wdata_q;
        else              rsp_rdata <= mem[addr_q];
      end
    end
  end

  // Request fields are only meaningful while in WAIT, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr[ADDR_W-1:0];
      wdata_q <= req_wdata;
      oor_q   <= oor_in;
    end
  end

  // Gating with rst keeps an abandoned write out of the array.
  always_ff @(posedge clk) begin
    if (!rst && access && write_q && !oor_q)
      mem[addr_q] <= wdata_q;
  end

endmodule
